// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter: owner encoding and
// the per-requester transaction bundle.
package mem_arb_pkg;

    localparam int ARB_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    // addr width tracks ARB_ADDR_WIDTH; the arbiter's ADDR_WIDTH should match it
    typedef struct packed {
        logic [ARB_ADDR_WIDTH-1:0] addr;
        logic                      wr;
        logic                      byt;
        logic [15:0]               wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one synchronous-read memory
// port between the CPU (M0) and the loader/DMA engine (M1).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  wr0,
    input  logic                  byt0,
    input  logic [15:0]           wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [15:0]           rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  wr1,
    input  logic                  byt1,
    input  logic [15:0]           wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [15:0]           rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic                  mem_byt,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    owner_t     owner_q, owner_d;
    owner_t     lastOwner_q;
    logic [7:0] burstCnt_q, burstCnt_d;
    logic       rvalid0_q, rvalid1_q;
    logic       txn0, txn1;
    arb_req_t   sel;

    function automatic owner_t next_owner(owner_t cur, owner_t last,
                                          logic r0, logic r1, logic expired);
        owner_t nxt;
        nxt = cur;
        case (cur)
            OWN_M0: begin
                if (!r0)                nxt = r1 ? OWN_M1 : OWN_NONE;
                else if (expired && r1) nxt = OWN_M1;
                else                    nxt = OWN_M0;
            end
            OWN_M1: begin
                if (!r1)                nxt = r0 ? OWN_M0 : OWN_NONE;
                else if (expired && r0) nxt = OWN_M0;
                else                    nxt = OWN_M1;
            end
            default: begin
                if (r0 && r1)  nxt = (last == OWN_M0) ? OWN_M1 : OWN_M0;
                else if (r0)   nxt = OWN_M0;
                else if (r1)   nxt = OWN_M1;
                else           nxt = OWN_NONE;
            end
        endcase
        return nxt;
    endfunction

    assign gnt0    = (owner_q == OWN_M0);
    assign gnt1    = (owner_q == OWN_M1);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

    // Gating with rst aborts any in-flight write during the reset cycle itself
    assign txn0 = gnt0 & req0 & ~rst;
    assign txn1 = gnt1 & req1 & ~rst;

    always_comb begin
        sel = '0;
        if (txn0)      sel = '{addr: addr0, wr: wr0, byt: byt0, wdata: wdata0};
        else if (txn1) sel = '{addr: addr1, wr: wr1, byt: byt1, wdata: wdata1};
    end

    assign mem_addr  = sel.addr;
    assign mem_wr    = sel.wr;
    assign mem_byt   = sel.byt;
    assign mem_wdata = sel.wdata;

    always_comb begin
        owner_d = next_owner(owner_q, lastOwner_q, req0, req1,
                             burstCnt_q == BURST_LAST);
        if (owner_d != owner_q || owner_d == OWN_NONE)
            burstCnt_d = 8'd0;
        else if ((txn0 || txn1) && burstCnt_q != BURST_LAST)
            burstCnt_d = burstCnt_q + 8'd1;
        else
            burstCnt_d = burstCnt_q;
    end

    // lastOwner starts at M1 so the first tie after reset goes to the CPU
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            lastOwner_q <= OWN_M1;
            burstCnt_q  <= 8'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            burstCnt_q <= burstCnt_d;
            if (owner_d != owner_q && owner_d != OWN_NONE)
                lastOwner_q <= owner_d;
            rvalid0_q <= txn0 & ~wr0;
            rvalid1_q <= txn1 & ~wr1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table for single transfers,
// hand sequences for burst alternation and mid-burst reset, read scoreboard.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, wr0, byt0, req1, wr1, byt1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_byt;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic        req0;
        logic [15:0] addr0;
        logic        wr0;
        logic        req1;
        logic [15:0] addr1;
        logic        wr1;
        logic [15:0] wdata1;
        logic        eGnt0;
        logic        eGnt1;
        logic        eWr;
        logic [15:0] eAddr;
        logic [15:0] eWdata;
    } vec_t;

    vec_t tbl [0:7];

    logic [15:0] memArr [0:65535];
    logic [15:0] refMem [0:65535];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    bit          pend0 = 0;
    bit          pend1 = 0;
    bit          sbOn  = 0;

    mem_arbiter #(.ADDR_WIDTH(16), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .wr0(wr0), .byt0(byt0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .wr1(wr1), .byt1(byt1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_byt(mem_byt),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req0 = v.req0; addr0 = v.addr0; wr0 = v.wr0; byt0 = 1'b0; wdata0 = 16'h0000;
        req1 = v.req1; addr1 = v.addr1; wr1 = v.wr1; byt1 = 1'b0; wdata1 = v.wdata1;
    endtask

    // Synchronous-read memory: data for the address seen at an edge appears after it
    initial begin
        for (int i = 0; i < 65536; i++) memArr[i] = 16'(i) ^ 16'hA5A5;
        memArr[16'h0200] = 16'h1234;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            mem_rdata <= memArr[mem_addr];
            if (mem_wr) memArr[mem_addr] = mem_wdata;
        end
    end

    // Read scoreboard driven from the bench's own view of issued transactions
    initial begin
        logic [15:0] exp;
        for (int i = 0; i < 65536; i++) refMem[i] = 16'(i) ^ 16'hA5A5;
        refMem[16'h0200] = 16'h1234;
        forever begin
            @(negedge clk);
            if (sbOn) begin
                checkOutput("rvalid0", {15'd0, rvalid0}, {15'd0, pend0});
                checkOutput("rvalid1", {15'd0, rvalid1}, {15'd0, pend1});
                if (pend0 && q0.size() > 0) begin
                    exp = q0.pop_front();
                    checkOutput("rdata0", rdata0, exp);
                end
                if (pend1 && q1.size() > 0) begin
                    exp = q1.pop_front();
                    checkOutput("rdata1", rdata1, exp);
                end
            end
            pend0 = !rst && req0 && gnt0 && !wr0;
            pend1 = !rst && req1 && gnt1 && !wr1;
            if (pend0) q0.push_back(refMem[addr0]);
            if (pend1) q1.push_back(refMem[addr1]);
            if (!rst && req0 && gnt0 && wr0) refMem[addr0] = wdata0;
            if (!rst && req1 && gnt1 && wr1) refMem[addr1] = wdata1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit gotGnt;

        tbl[0] = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000};
        tbl[2] = '{1'b0, 16'h0200, 1'b0, 1'b1, 16'h0300, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 16'h0200, 1'b0, 1'b1, 16'h0300, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0300, 16'hBEEF};
        tbl[4] = '{1'b1, 16'h0300, 1'b0, 1'b0, 16'h0300, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000};
        tbl[6] = '{1'b0, 16'h0300, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

        rst = 1'b1;
        req0 = 0; addr0 = 0; wr0 = 0; byt0 = 0; wdata0 = 0;
        req1 = 0; addr1 = 0; wr1 = 0; byt1 = 0; wdata1 = 0;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rstGnt0", {15'd0, gnt0}, 16'd0);
        checkOutput("rstGnt1", {15'd0, gnt1}, 16'd0);
        checkOutput("rstRvalid0", {15'd0, rvalid0}, 16'd0);
        checkOutput("rstMemAddr", mem_addr, 16'h0000);
        sbOn = 1;
        nextCycle();
        rst = 1'b0;

        $display("[TB] vector table: single read, M1 write then M0 readback, dropped req");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d.gnt0", i), {15'd0, gnt0}, {15'd0, tbl[i].eGnt0});
            checkOutput($sformatf("v%0d.gnt1", i), {15'd0, gnt1}, {15'd0, tbl[i].eGnt1});
            checkOutput($sformatf("v%0d.memWr", i), {15'd0, mem_wr}, {15'd0, tbl[i].eWr});
            checkOutput($sformatf("v%0d.memAddr", i), mem_addr, tbl[i].eAddr);
            checkOutput($sformatf("v%0d.memWdata", i), mem_wdata, tbl[i].eWdata);
            nextCycle();
        end

        $display("[TB] contention: 8-transaction bursts alternate with no idle gap");
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        req0 = 1; addr0 = 16'h0210; wr0 = 0;
        req1 = 1; addr1 = 16'h0400; wr1 = 0; wdata1 = 16'h0000;
        @(negedge clk);
        checkOutput("tieIdleGnt0", {15'd0, gnt0}, 16'd0);
        checkOutput("tieIdleGnt1", {15'd0, gnt1}, 16'd0);
        nextCycle();
        for (int k = 1; k <= 40; k++) begin
            logic expM0;
            expM0 = (((k - 1) / 8) % 2) == 0;
            @(negedge clk);
            checkOutput($sformatf("burst%0d.gnt0", k), {15'd0, gnt0}, {15'd0, expM0});
            checkOutput($sformatf("burst%0d.gnt1", k), {15'd0, gnt1}, {15'd0, ~expM0});
            if (k == 9) begin
                checkOutput("handoffRvalid0", {15'd0, rvalid0}, 16'd1);
                checkOutput("handoffRvalid1", {15'd0, rvalid1}, 16'd0);
                checkOutput("handoffRdata0", rdata0, 16'hA7B5);
            end
            if (k == 17) begin
                checkOutput("backRvalid1", {15'd0, rvalid1}, 16'd1);
                checkOutput("backRvalid0", {15'd0, rvalid0}, 16'd0);
            end
            nextCycle();
        end

        $display("[TB] reset during an M1 write burst");
        req0 = 0;
        req1 = 1; addr1 = 16'h0500; wr1 = 1; wdata1 = 16'hCAFE;
        gotGnt = 0;
        for (int w = 0; w < 10 && !gotGnt; w++) begin
            @(negedge clk);
            if (gnt1) gotGnt = 1;
            else nextCycle();
        end
        checkOutput("waitGnt1", {15'd0, gotGnt}, 16'd1);
        nextCycle();
        addr1 = 16'h0502; wdata1 = 16'hD00D;
        nextCycle();
        addr1 = 16'h0504; wdata1 = 16'h1111;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstCycMemWr", {15'd0, mem_wr}, 16'd0);
        checkOutput("rstCycMemAddr", mem_addr, 16'h0000);
        checkOutput("rstCycMemWdata", mem_wdata, 16'h0000);
        nextCycle();
        @(negedge clk);
        checkOutput("rstHeldGnt1", {15'd0, gnt1}, 16'd0);
        checkOutput("rstHeldGnt0", {15'd0, gnt0}, 16'd0);
        nextCycle();
        rst = 1'b0;
        req0 = 1; addr0 = 16'h0504; wr0 = 0;
        req1 = 1; addr1 = 16'h0500; wr1 = 0; wdata1 = 16'h0000;
        @(negedge clk);
        checkOutput("postRstIdleGnt0", {15'd0, gnt0}, 16'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("postRstTieGnt0", {15'd0, gnt0}, 16'd1);
        checkOutput("postRstTieGnt1", {15'd0, gnt1}, 16'd0);
        nextCycle();
        req0 = 0;
        nextCycle();
        req1 = 0;
        repeat (4) nextCycle();
        @(negedge clk);
        checkOutput("sbDrain", 16'(q0.size() + q1.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
